// File: rtl/writeback_queue_pkg.sv
// ---------------------------------------------------------------------------
// writeback_queue_pkg
// Shared definitions for the writeback queue slice.
//   - Default parameter values for the data word and register index widths
//     and the queue depth.
//   - State encoding for the drain controller (RUN / DRAIN).
// No ports: imported by wb_fifo and writeback_queue.
// ---------------------------------------------------------------------------
package writeback_queue_pkg;

    localparam int DEFAULT_WORD_LENGTH = 16;
    localparam int DEFAULT_ID_LENGTH   = 3;
    localparam int DEFAULT_DEPTH       = 4;

    typedef enum logic {
        STATE_RUN   = 1'b0,
        STATE_DRAIN = 1'b1
    } wbq_state_t;

endpackage

// File: rtl/writeback_queue_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Storage and pointer logic for the writeback queue. A DEPTH-entry circular
// buffer of (register index, data) pairs with a per-entry valid bit so the
// parent can compare every queued destination against decode-stage queries.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   push              enqueue push_reg/push_data (ignored when full)
//   pop               dequeue head entry (ignored when empty)
//   push_reg          destination register index to enqueue
//   push_data         data word to enqueue
//   full, empty       occupancy flags
//   count             number of queued entries (0..DEPTH)
//   head_reg          register index of the oldest entry
//   head_data         data word of the oldest entry
//   entry_valid       per-slot valid bits
//   entry_reg         per-slot register indices
// ---------------------------------------------------------------------------
module wb_fifo
    import writeback_queue_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
    parameter int ID_LENGTH   = DEFAULT_ID_LENGTH,
    parameter int DEPTH       = DEFAULT_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic [ID_LENGTH-1:0]             push_reg,
    input  logic [WORD_LENGTH-1:0]           push_data,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH):0]           count,
    output logic [ID_LENGTH-1:0]             head_reg,
    output logic [WORD_LENGTH-1:0]           head_data,
    output logic [DEPTH-1:0]                 entry_valid,
    output logic [DEPTH-1:0][ID_LENGTH-1:0]  entry_reg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ID_LENGTH-1:0] reg_mem;
    logic [WORD_LENGTH-1:0]          data_mem [DEPTH];
    logic [DEPTH-1:0]                valid_q;
    logic [PTR_W-1:0]                rd_ptr;
    logic [PTR_W-1:0]                wr_ptr;
    logic [CNT_W-1:0]                count_q;

    logic do_push;
    logic do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);

    // Guard against overflow/underflow so a push and pop can never target
    // the same slot on one edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Entry payload storage needs no reset: the valid bits and the count
    // decide whether a slot means anything.
    always_ff @(posedge clk) begin
        if (do_push) begin
            reg_mem[wr_ptr]  <= push_reg;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (do_push) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count       = count_q;
    assign head_reg    = reg_mem[rd_ptr];
    assign head_data   = data_mem[rd_ptr];
    assign entry_valid = valid_q;
    assign entry_reg   = reg_mem;

endmodule

// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue
// Buffers register-file writebacks and retires them one per cycle through a
// registered write port. Reports whether a decode-stage source register
// still has a write outstanding, and supports draining the queue.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   wb_valid/wb_reg/wb_data  writeback request
//   wb_ready                 request accepted when high together with wb_valid
//   write_reg/write_data     registered register-file write port
//   write_reg_en             one-cycle write pulse per retired entry
//   query_reg1/query_reg2    decode-stage source indices
//   pending1/pending2        write outstanding for the queried register
//   drain                    stop accepting and empty the queue
//   drain_done               one-cycle pulse when the drain completes
//   count                    number of queued entries
// ---------------------------------------------------------------------------
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
    parameter int ID_LENGTH   = DEFAULT_ID_LENGTH,
    parameter int DEPTH       = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_valid,
    input  logic [ID_LENGTH-1:0]   wb_reg,
    input  logic [WORD_LENGTH-1:0] wb_data,
    output logic                   wb_ready,
    output logic [ID_LENGTH-1:0]   write_reg,
    output logic [WORD_LENGTH-1:0] write_data,
    output logic                   write_reg_en,
    input  logic [ID_LENGTH-1:0]   query_reg1,
    input  logic [ID_LENGTH-1:0]   query_reg2,
    output logic                   pending1,
    output logic                   pending2,
    input  logic                   drain,
    output logic                   drain_done,
    output logic [$clog2(DEPTH):0] count
);

    wbq_state_t                      state;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic                            push;
    logic                            pop;
    logic [ID_LENGTH-1:0]            head_reg;
    logic [WORD_LENGTH-1:0]          head_data;
    logic [DEPTH-1:0]                entry_valid;
    logic [DEPTH-1:0][ID_LENGTH-1:0] entry_reg;

    // Register 0 is hard-wired to zero, so such requests are acknowledged
    // but never stored; the head is retired whenever anything is queued.
    assign wb_ready = !fifo_full && (state == STATE_RUN);
    assign push     = wb_valid && wb_ready && (wb_reg != '0);
    assign pop      = !fifo_empty;

    wb_fifo #(
        .WORD_LENGTH (WORD_LENGTH),
        .ID_LENGTH   (ID_LENGTH),
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .push_reg    (wb_reg),
        .push_data   (wb_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (count),
        .head_reg    (head_reg),
        .head_data   (head_data),
        .entry_valid (entry_valid),
        .entry_reg   (entry_reg)
    );

    // Output stage: the write port holds its last index/data between
    // pulses; only the enable is a strict one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg_en <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
        end else if (pop) begin
            write_reg_en <= 1'b1;
            write_reg    <= head_reg;
            write_data   <= head_data;
        end else begin
            write_reg_en <= 1'b0;
        end
    end

    // Drain controller. DRAIN waits until both the queue and the output
    // stage are idle, so the last write has been seen by the register file
    // before drain_done is raised. A drain request while draining is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STATE_RUN;
            drain_done <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            case (state)
                STATE_RUN: begin
                    if (drain) begin
                        state <= STATE_DRAIN;
                    end
                end
                STATE_DRAIN: begin
                    if (fifo_empty && !write_reg_en) begin
                        state      <= STATE_RUN;
                        drain_done <= 1'b1;
                    end
                end
                default: begin
                    state <= STATE_RUN;
                end
            endcase
        end
    end

    // A query hits if any live queue slot or the in-flight output write
    // targets the same register. Register 0 never reports pending.
    always_comb begin
        logic hit1;
        logic hit2;
        hit1 = write_reg_en && (write_reg == query_reg1);
        hit2 = write_reg_en && (write_reg == query_reg2);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_reg[i] == query_reg1)) begin
                hit1 = 1'b1;
            end
            if (entry_valid[i] && (entry_reg[i] == query_reg2)) begin
                hit2 = 1'b1;
            end
        end
        pending1 = hit1 && (query_reg1 != '0);
        pending2 = hit2 && (query_reg2 != '0);
    end

endmodule
